// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-type encodings,
// FSM states, latency limits and the alignment rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_WORD  = 2'b00,
        DMEM_HALF  = 2'b01,
        DMEM_BYTE  = 2'b10,
        DMEM_BYTEU = 2'b11
    } dmem_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    function automatic logic is_misaligned(input dmem_type_e kind, input logic [1:0] offset);
        case (kind)
            DMEM_WORD: return offset != 2'b00;
            DMEM_HALF: return offset[0];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads,
// plus the misalignment flag for the current access.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  dmem_type_e  kind,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        misalign = is_misaligned(kind, offset);
        half_sel = offset[1] ? rword[31:16] : rword[15:0];
        byte_sel = rword[7:0];
        case (offset)
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            2'd3:    byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase

        byte_en = 4'b0000;
        wword   = wdata;
        rdata   = 32'h0;
        // Sub-word store data is replicated so the byte enables alone pick the lane
        case (kind)
            DMEM_WORD: begin
                byte_en = 4'b1111;
                wword   = wdata;
                rdata   = rword;
            end
            DMEM_HALF: begin
                byte_en = offset[1] ? 4'b1100 : 4'b0011;
                wword   = {2{wdata[15:0]}};
                rdata   = {{16{half_sel[15]}}, half_sel};
            end
            DMEM_BYTE: begin
                byte_en = 4'b0001 << offset;
                wword   = {4{wdata[7:0]}};
                rdata   = {{24{byte_sel[7]}}, byte_sel};
            end
            default: begin
                byte_en = 4'b0001 << offset;
                wword   = {4{wdata[7:0]}};
                rdata   = {24'h0, byte_sel};
            end
        endcase

        if (misalign) begin
            byte_en = 4'b0000;
            rdata   = 32'h0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with single-cycle stores and
// fixed-latency loads behind a ready/valid handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_dmem_ena,
    input  logic        in_dmem_wena,
    input  logic [1:0]  in_dmem_type,
    input  logic [31:0] in_dmem_addr,
    input  logic [31:0] in_dmem_wdata,
    output logic        out_dmem_ready,
    output logic        out_dmem_valid,
    output logic [31:0] out_dmem_rdata,
    output logic        out_dmem_misalign,
    output logic [31:0] out_load_count,
    output logic [31:0] out_store_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_READ_LATENCY);
    // Out-of-range latencies are clamped to the supported window
    localparam int LAT = (READ_LATENCY < MIN_READ_LATENCY) ? MIN_READ_LATENCY :
                         (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY : READ_LATENCY;
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LAT - 1);

    dmem_state_e      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    dmem_type_e       lat_kind;
    logic [1:0]       lat_offset;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      mem [DEPTH];

    dmem_type_e       sel_kind;
    logic [1:0]       sel_offset;
    logic [IDX_W-1:0] req_idx;
    logic             accept, accept_store, accept_load;
    logic [3:0]       byte_en;
    logic [31:0]      wword, rword, align_rdata;
    logic             align_misalign;
    logic             unused_addr_bits;

    assign out_dmem_ready   = (state == IDLE);
    assign accept           = in_dmem_ena & out_dmem_ready;
    assign accept_store     = accept & in_dmem_wena;
    assign accept_load      = accept & ~in_dmem_wena;
    assign req_idx          = in_dmem_addr[IDX_W+1:2];
    assign unused_addr_bits = ^in_dmem_addr[31:IDX_W+2];

    // New requests are steered from the live inputs; responses use the latched access
    assign sel_kind   = out_dmem_ready ? dmem_type_e'(in_dmem_type) : lat_kind;
    assign sel_offset = out_dmem_ready ? in_dmem_addr[1:0] : lat_offset;
    assign rword      = mem[lat_idx];

    dmem_lane_align u_align (
        .kind     (sel_kind),
        .offset   (sel_offset),
        .wdata    (in_dmem_wdata),
        .rword    (rword),
        .byte_en  (byte_en),
        .wword    (wword),
        .rdata    (align_rdata),
        .misalign (align_misalign)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept_load) begin
                    cnt_next   = LOAD_CNT;
                    state_next = (LOAD_CNT == '0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state             <= IDLE;
            cnt               <= '0;
            lat_kind          <= DMEM_WORD;
            lat_offset        <= '0;
            lat_idx           <= '0;
            out_dmem_valid    <= 1'b0;
            out_dmem_rdata    <= 32'h0;
            out_dmem_misalign <= 1'b0;
            out_load_count    <= 32'h0;
            out_store_count   <= 32'h0;
        end else begin
            state             <= state_next;
            cnt               <= cnt_next;
            out_dmem_valid    <= 1'b0;
            out_dmem_misalign <= 1'b0;
            if (accept_store) begin
                out_store_count   <= out_store_count + 32'd1;
                out_dmem_misalign <= align_misalign;
            end
            if (accept_load) begin
                out_load_count <= out_load_count + 32'd1;
                lat_kind       <= dmem_type_e'(in_dmem_type);
                lat_offset     <= in_dmem_addr[1:0];
                lat_idx        <= req_idx;
            end
            if (state == RESP) begin
                out_dmem_valid    <= 1'b1;
                out_dmem_rdata    <= align_rdata;
                out_dmem_misalign <= align_misalign;
            end
        end
    end

    // RAM is deliberately left out of reset so data survives an abandoned load
    always_ff @(posedge in_clk) begin
        if (!in_rst && accept_store) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[req_idx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at latency 1, one at latency 3.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena_a, ena_b;
    logic        wena;
    logic [1:0]  typ;
    logic [31:0] addr, wdata;

    logic        ready_a, valid_a, mis_a;
    logic [31:0] rdata_a, lc_a, sc_a;
    logic        ready_b, valid_b, mis_b;
    logic [31:0] rdata_b, lc_b, sc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .READ_LATENCY(1)) dut_a (
        .in_clk(clk), .in_rst(rst), .in_dmem_ena(ena_a), .in_dmem_wena(wena),
        .in_dmem_type(typ), .in_dmem_addr(addr), .in_dmem_wdata(wdata),
        .out_dmem_ready(ready_a), .out_dmem_valid(valid_a), .out_dmem_rdata(rdata_a),
        .out_dmem_misalign(mis_a), .out_load_count(lc_a), .out_store_count(sc_a)
    );

    dmem_responder #(.DEPTH(1024), .READ_LATENCY(3)) dut_b (
        .in_clk(clk), .in_rst(rst), .in_dmem_ena(ena_b), .in_dmem_wena(wena),
        .in_dmem_type(typ), .in_dmem_addr(addr), .in_dmem_wdata(wdata),
        .out_dmem_ready(ready_b), .out_dmem_valid(valid_b), .out_dmem_rdata(rdata_b),
        .out_dmem_misalign(mis_b), .out_load_count(lc_b), .out_store_count(sc_b)
    );

    task automatic do_store(input bit sel, input logic [1:0] t, input logic [31:0] a,
                            input logic [31:0] d, output logic mis);
        @(negedge clk);
        wena = 1'b1; typ = t; addr = a; wdata = d;
        if (sel) ena_b = 1'b1; else ena_a = 1'b1;
        @(posedge clk); #1;
        mis = sel ? mis_b : mis_a;
        ena_a = 1'b0; ena_b = 1'b0;
    endtask

    task automatic do_load(input bit sel, input logic [1:0] t, input logic [31:0] a,
                           output logic [31:0] data, output logic mis, output int lat);
        int n;
        @(negedge clk);
        wena = 1'b0; typ = t; addr = a;
        if (sel) ena_b = 1'b1; else ena_a = 1'b1;
        @(posedge clk); #1;
        ena_a = 1'b0; ena_b = 1'b0;
        lat = -1; data = 'x; mis = 'x; n = 0;
        while (lat < 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
            if ((sel ? valid_b : valid_a) === 1'b1) begin
                lat  = n;
                data = sel ? rdata_b : rdata_a;
                mis  = sel ? mis_b : mis_a;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ena_a = 1'b0; ena_b = 1'b0;
        wena = 1'b0; typ = 2'b00; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_a: got %b expected 1", ready_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid_a: got %b expected 0", valid_a); end
        checks++; if (rdata_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata_a: got %h expected 0", rdata_a); end
        checks++; if (mis_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign_a: got %b expected 0", mis_a); end
        checks++; if (lc_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_load_count_a: got %0d expected 0", lc_a); end
        checks++; if (sc_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_store_count_a: got %0d expected 0", sc_a); end
        checks++; if (ready_b !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_b: got %b expected 1", ready_b); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        logic mis; logic [31:0] data; int lat;
        do_store(0, 2'b00, 32'h10, 32'h12345678, mis);
        checks++; if (mis !== 1'b0) begin errors++; $display("[TB] FAIL word_store_misalign: got %b expected 0", mis); end
        do_load(0, 2'b00, 32'h10, data, mis, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL word_latency: got %0d expected 1", lat); end
        checks++; if (data !== 32'h12345678) begin errors++; $display("[TB] FAIL word_rdata: got %h expected 12345678", data); end
        checks++; if (mis !== 1'b0) begin errors++; $display("[TB] FAIL word_misalign: got %b expected 0", mis); end
        checks++; if (lc_a !== 32'd1) begin errors++; $display("[TB] FAIL word_load_count: got %0d expected 1", lc_a); end
        checks++; if (sc_a !== 32'd1) begin errors++; $display("[TB] FAIL word_store_count: got %0d expected 1", sc_a); end
    endtask

    task automatic test_byte();
        logic mis; logic [31:0] data; int lat;
        do_store(0, 2'b00, 32'h20, 32'h11223344, mis);
        do_store(0, 2'b10, 32'h21, 32'hAAAAAA80, mis);
        do_load(0, 2'b10, 32'h21, data, mis, lat);
        checks++; if (data !== 32'hFFFFFF80) begin errors++; $display("[TB] FAIL byte_signed: got %h expected ffffff80", data); end
        do_load(0, 2'b11, 32'h21, data, mis, lat);
        checks++; if (data !== 32'h00000080) begin errors++; $display("[TB] FAIL byte_unsigned: got %h expected 00000080", data); end
        do_load(0, 2'b00, 32'h20, data, mis, lat);
        checks++; if (data !== 32'h11228044) begin errors++; $display("[TB] FAIL byte_word_view: got %h expected 11228044", data); end
        do_load(0, 2'b11, 32'h23, data, mis, lat);
        checks++; if (data !== 32'h00000011) begin errors++; $display("[TB] FAIL byte_lane3: got %h expected 00000011", data); end
        checks++; if (sc_a !== 32'd3) begin errors++; $display("[TB] FAIL byte_store_count: got %0d expected 3", sc_a); end
        checks++; if (lc_a !== 32'd5) begin errors++; $display("[TB] FAIL byte_load_count: got %0d expected 5", lc_a); end
    endtask

    task automatic test_half();
        logic mis; logic [31:0] data; int lat;
        do_store(0, 2'b00, 32'h30, 32'h55667788, mis);
        do_store(0, 2'b01, 32'h32, 32'h1234BEEF, mis);
        do_load(0, 2'b01, 32'h32, data, mis, lat);
        checks++; if (data !== 32'hFFFFBEEF) begin errors++; $display("[TB] FAIL half_upper: got %h expected ffffbeef", data); end
        do_load(0, 2'b01, 32'h30, data, mis, lat);
        checks++; if (data !== 32'h00007788) begin errors++; $display("[TB] FAIL half_lower: got %h expected 00007788", data); end
        do_load(0, 2'b00, 32'h31, data, mis, lat);
        checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL misload_latency: got %0d expected 1", lat); end
        checks++; if (mis !== 1'b1) begin errors++; $display("[TB] FAIL misload_flag: got %b expected 1", mis); end
        checks++; if (data !== 32'h0) begin errors++; $display("[TB] FAIL misload_rdata: got %h expected 0", data); end
        do_store(0, 2'b00, 32'h33, 32'hDEADDEAD, mis);
        checks++; if (mis !== 1'b1) begin errors++; $display("[TB] FAIL misstore_flag: got %b expected 1", mis); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL misstore_valid: got %b expected 0", valid_a); end
        checks++; if (sc_a !== 32'd6) begin errors++; $display("[TB] FAIL misstore_count: got %0d expected 6", sc_a); end
        @(posedge clk); #1;
        checks++; if (mis_a !== 1'b0) begin errors++; $display("[TB] FAIL misstore_pulse_end: got %b expected 0", mis_a); end
        do_load(0, 2'b00, 32'h30, data, mis, lat);
        checks++; if (data !== 32'hBEEF7788) begin errors++; $display("[TB] FAIL misstore_no_write: got %h expected beef7788", data); end
        checks++; if (lc_a !== 32'd9) begin errors++; $display("[TB] FAIL half_load_count: got %0d expected 9", lc_a); end
    endtask

    task automatic test_wrap();
        logic mis; logic [31:0] data; int lat;
        do_store(0, 2'b00, 32'h0, 32'hCAFEF00D, mis);
        do_load(0, 2'b00, 32'h1000, data, mis, lat);
        checks++; if (data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL wrap_load: got %h expected cafef00d", data); end
        do_store(0, 2'b10, 32'h1003, 32'h0000005A, mis);
        do_load(0, 2'b00, 32'h0, data, mis, lat);
        checks++; if (data !== 32'h5AFEF00D) begin errors++; $display("[TB] FAIL wrap_store: got %h expected 5afef00d", data); end
    endtask

    task automatic test_back_to_back();
        logic mis; logic [31:0] data; int lat;
        do_store(1, 2'b00, 32'h40, 32'hA5A5A5A5, mis);
        @(negedge clk);
        wena = 1'b0; typ = 2'b00; addr = 32'h40; ena_b = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            checks++; if (ready_b !== 1'b0) begin errors++; $display("[TB] FAIL lat3_ready_low%0d: got %b expected 0", i, ready_b); end
            checks++; if (valid_b !== 1'b0) begin errors++; $display("[TB] FAIL lat3_early_valid%0d: got %b expected 0", i, valid_b); end
            checks++; if (lc_b !== 32'd1) begin errors++; $display("[TB] FAIL lat3_count_held%0d: got %0d expected 1", i, lc_b); end
        end
        @(posedge clk); #1;
        checks++; if (valid_b !== 1'b1) begin errors++; $display("[TB] FAIL lat3_valid: got %b expected 1", valid_b); end
        checks++; if (rdata_b !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL lat3_rdata: got %h expected a5a5a5a5", rdata_b); end
        checks++; if (ready_b !== 1'b1) begin errors++; $display("[TB] FAIL lat3_ready_after: got %b expected 1", ready_b); end
        @(posedge clk); #1;
        ena_b = 1'b0;
        checks++; if (lc_b !== 32'd2) begin errors++; $display("[TB] FAIL lat3_held_accept: got %0d expected 2", lc_b); end
        checks++; if (ready_b !== 1'b0) begin errors++; $display("[TB] FAIL lat3_second_busy: got %b expected 0", ready_b); end
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (valid_b === 1'b1) begin lat = i; data = rdata_b; end
        end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL lat3_second_latency: got %0d expected 3", lat); end
        checks++; if (data !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL lat3_second_rdata: got %h expected a5a5a5a5", data); end
    endtask

    task automatic test_reset_mid_load();
        logic mis; logic [31:0] data; int lat; bit seen;
        do_store(1, 2'b00, 32'h50, 32'h0BADBEEF, mis);
        do_store(0, 2'b00, 32'h60, 32'h77777777, mis);
        @(negedge clk);
        wena = 1'b0; typ = 2'b00; addr = 32'h50; ena_b = 1'b1;
        @(posedge clk); #1;
        ena_b = 1'b0;
        checks++; if (ready_b !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", ready_b); end
        @(negedge clk);
        rst = 1'b1;
        wena = 1'b1; typ = 2'b00; addr = 32'h60; wdata = 32'h00000001; ena_a = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_b !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready: got %b expected 1", ready_b); end
        checks++; if (lc_b !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_load_count: got %0d expected 0", lc_b); end
        checks++; if (sc_b !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_store_count: got %0d expected 0", sc_b); end
        checks++; if (sc_a !== 32'h0) begin errors++; $display("[TB] FAIL rstedge_store_count: got %0d expected 0", sc_a); end
        @(negedge clk);
        rst = 1'b0; ena_a = 1'b0;
        seen = valid_b;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid_b !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_valid: got %b expected 0", seen); end
        do_load(1, 2'b00, 32'h50, data, mis, lat);
        checks++; if (data !== 32'h0BADBEEF) begin errors++; $display("[TB] FAIL rstmid_data_kept: got %h expected 0badbeef", data); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL rstmid_latency: got %0d expected 3", lat); end
        do_load(0, 2'b00, 32'h60, data, mis, lat);
        checks++; if (data !== 32'h77777777) begin errors++; $display("[TB] FAIL rstedge_no_store: got %h expected 77777777", data); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wrap();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's MEM-stage load/store requests. The CPU pipeline is the initiator; this block is the memory end of that interface.
- Holds a word-organised RAM with byte/half/word access and sign/zero extension on loads.
- Stores complete in one cycle. Loads have a configurable latency with a ready/valid handshake and misalignment reporting.
- Also keeps load/store activity counters for the result/debug outputs.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two; index = in_dmem_addr[log2(DEPTH)+1:2].
- READ_LATENCY, 1, cycles from load accept to out_dmem_valid; legal range 1..4.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_dmem_ena  input  1  request strobe; sampled only while out_dmem_ready=1.
- in_dmem_wena  input  1  1=store, 0=load.
- in_dmem_type  input  2  00 word, 01 half signed, 10 byte signed, 11 byte unsigned.
- in_dmem_addr  input  32  byte address.
- in_dmem_wdata  input  32  store data; low half/byte used for sub-word stores.
- out_dmem_ready  output  1  block can accept a request this cycle.
- out_dmem_valid  output  1  one-cycle pulse; load response present.
- out_dmem_rdata  output  32  extended load data; held until next valid.
- out_dmem_misalign  output  1  qualifies valid, or pulses on a rejected store.
- out_load_count  output  32  accepted loads, wraps.
- out_store_count  output  32  accepted stores, including misaligned ones, wraps.

Behaviour:
- Reset (in_rst=1 at an edge):
  - FSM goes to IDLE.
  - out_dmem_ready=1; out_dmem_valid=0; out_dmem_rdata=0; out_dmem_misalign=0; both counters=0.
  - RAM contents are not cleared.
- Accept condition: in_dmem_ena & out_dmem_ready at a rising edge.
- Misalignment check:
  - word: addr[1:0]!=0 is misaligned.
  - half: addr[0]!=0 is misaligned.
  - byte: never misaligned.
- Store accept:
  - Aligned: write byte lanes selected by addr[1:0] and type in the same edge.
    - word: all 4 lanes.
    - half: lanes {addr[1],0}..+1 get wdata[15:0].
    - byte: lane addr[1:0] gets wdata[7:0].
  - Misaligned: no write; out_dmem_misalign pulses 1 cycle with valid=0.
  - out_store_count += 1 in either case.
  - FSM stays IDLE; ready stays 1, so back-to-back stores run every cycle.
- Load accept:
  - out_load_count += 1.
  - Latch addr and type; FSM goes IDLE->BUSY and loads the countdown with READ_LATENCY-1.
  - ready=0 while BUSY.
  - If READ_LATENCY=1, the FSM goes directly to RESP.
- BUSY: decrement each cycle; at 0 go to RESP.
- RESP (1 cycle):
  - out_dmem_valid=1 and out_dmem_rdata updated.
  - ready=0 in this cycle; return to IDLE next edge.
  - The earliest next accept is the edge after RESP.
  - Net effect: the valid pulse comes READ_LATENCY cycles after accept.
- Load data:
  - Read word at latched index, then extract and extend per type (byte 0x80 signed becomes 0xFFFFFF80).
  - Misaligned load: rdata=0 and misalign=1 alongside valid.
- Read data reflects RAM contents at the RESP edge, which includes any store accepted earlier (stores cannot overlap a load).
- Requests while ready=0 are ignored and not counted; the requester holds the request.
- Address wrap: bits above the index field are ignored; addr DEPTH*4 aliases word 0.
- Counter overflow: 0xFFFFFFFF + 1 -> 0.
- Reset mid-load: in-flight load is abandoned, no valid pulse, counters zeroed; a store on the reset edge is not performed.
- in_dmem_wena/type/wdata are don't-care when in_dmem_ena=0.

Decomposition:
- Shared package dmem_pkg:
  - type encodings DMEM_WORD/DMEM_HALF/DMEM_BYTE/DMEM_BYTEU.
  - FSM state enum IDLE/BUSY/RESP.
  - Misalignment function.
  - Latency range constants.
- Sub-module dmem_lane_align (combinational): from type, addr[1:0] and wdata, produces byte-enables and the write word; from the read word, produces the extended rdata and the misalign flag. The top holds the RAM, FSM and counters.

Test Plan:
- Reset, then store word 0x12345678 @0x10, then load word @0x10 with READ_LATENCY=1 -> valid next cycle, rdata=0x12345678, misalign=0, load_count=1, store_count=1.
- Store byte 0x80 @0x21, then load byte signed @0x21 -> 0xFFFFFF80; load byte unsigned @0x21 -> 0x00000080; load word @0x20 -> byte lane 1 is 0x80, other lanes unchanged.
- Store half 0xBEEF @0x32, then load half @0x32 -> 0xFFFFBEEF; load word @0x31 -> valid with misalign=1, rdata=0; store word @0x33 -> misalign pulse, memory unchanged, store_count incremented.
- READ_LATENCY=3: load accepted at edge N -> ready low for 3 cycles, valid at N+3; a request held during BUSY is accepted only after RESP, and counts increment once.
- Assert in_rst during BUSY -> no valid pulse, ready=1 and counters=0 next cycle; a later load returns the pre-reset stored data.
- Store 0xCAFEF00D @0x0, then load @DEPTH*4 -> 0xCAFEF00D (address wrap).
